// File: rtl/fp_ret_pkg.sv
// Shared constants and the retire-queue entry layout for the FP retire collector.
package fp_ret_pkg;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_STALL_THR = 5;
    localparam int RET_W         = 14;
    localparam int NUM_LANES     = 3;

    localparam logic [1:0] LANE_U1 = 2'd0;
    localparam logic [1:0] LANE_U3 = 2'd1;
    localparam logic [1:0] LANE_U5 = 2'd2;

    typedef struct packed {
        logic [1:0]       lane;
        logic [RET_W-1:0] ret;
    } fp_ret_entry_t;
endpackage

// File: rtl/fp_ret_fifo.sv
// Circular buffer taking up to NUM_LANES compacted writes and one read per cycle.
module fp_ret_fifo
    import fp_ret_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [1:0]                      wr_cnt,
    input  fp_ret_entry_t [NUM_LANES-1:0]   wr_data,
    input  logic                            rd_en,
    output fp_ret_entry_t                   rd_data,
    output logic [$clog2(DEPTH):0]          count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head, tail;
    fp_ret_entry_t mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (rd_en) head <= head + 1'b1;
            tail  <= tail + PW'(wr_cnt);
            count <= count + CW'(wr_cnt) - CW'(rd_en);
        end
    end

    // Storage is left unreset; the empty check below masks stale slots.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (i < int'(wr_cnt)) mem[tail + PW'(i)] <= wr_data[i];
            end
        end
    end

    assign rd_data = (count != '0) ? mem[head] : '0;
endmodule

// File: rtl/fp_ret_collect.sv
// Collects retire codes from three FP store lanes into one ordered queue with
// backpressure (stall) and a sticky drop flag (ovf).
module fp_ret_collect
    import fp_ret_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int STALL_THR = DEF_STALL_THR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [13:0]            u1_ret,
    input  logic                   u1_ret_en,
    input  logic [13:0]            u3_ret,
    input  logic                   u3_ret_en,
    input  logic [13:0]            u5_ret,
    input  logic                   u5_ret_en,
    input  logic                   flush,
    output logic [15:0]            ret_out,
    output logic                   ret_out_vld,
    input  logic                   ret_out_rdy,
    output logic                   stall,
    output logic                   ovf,
    output logic [$clog2(DEPTH):0] count
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [NUM_LANES-1:0]          lane_en;
    fp_ret_entry_t [NUM_LANES-1:0] lane_entry;
    fp_ret_entry_t [NUM_LANES-1:0] cmp_entry;
    fp_ret_entry_t                 head_entry;
    logic [1:0]                    n_vld;
    logic [1:0]                    wr_cnt;
    logic [CW:0]                   space;
    logic                          pop;
    logic                          over;
    logic                          drop;

    assign lane_en       = {u5_ret_en, u3_ret_en, u1_ret_en};
    assign lane_entry[0] = {LANE_U1, u1_ret};
    assign lane_entry[1] = {LANE_U3, u3_ret};
    assign lane_entry[2] = {LANE_U5, u5_ret};

    // Pack valid lanes to the low slots in u1, u3, u5 order so that
    // truncating to the free space drops u5 first, then u3, then u1.
    always_comb begin
        cmp_entry = '0;
        n_vld     = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_en[i]) begin
                cmp_entry[n_vld] = lane_entry[i];
                n_vld            = n_vld + 2'd1;
            end
        end
    end

    always_comb begin
        pop    = ret_out_vld & ret_out_rdy;
        space  = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop);
        over   = (CW+1)'(n_vld) > space;
        drop   = over & ~flush;
        wr_cnt = '0;
        if (!flush) wr_cnt = over ? space[1:0] : n_vld;
    end

    fp_ret_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_cnt  (wr_cnt),
        .wr_data (cmp_entry),
        .rd_en   (pop),
        .rd_data (head_entry),
        .count   (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      ovf <= 1'b0;
        else if (drop) ovf <= 1'b1;
    end

    assign ret_out     = head_entry;
    assign ret_out_vld = (count != '0);
    assign stall       = count > CW'(STALL_THR);
endmodule

// File: tb/tb_fp_ret_collect.sv
// Directed and scoreboard-checked stimulus for fp_ret_collect at default parameters.
module tb_fp_ret_collect;
    logic        clk, rst;
    logic [13:0] u1_ret, u3_ret, u5_ret;
    logic        u1_ret_en, u3_ret_en, u5_ret_en;
    logic        flush, ret_out_rdy;
    logic [15:0] ret_out;
    logic        ret_out_vld, stall, ovf;
    logic [3:0]  count;

    int n_chk = 0;
    int n_err = 0;
    logic [15:0] q[$];

    fp_ret_collect dut (
        .clk(clk), .rst(rst),
        .u1_ret(u1_ret), .u1_ret_en(u1_ret_en),
        .u3_ret(u3_ret), .u3_ret_en(u3_ret_en),
        .u5_ret(u5_ret), .u5_ret_en(u5_ret_en),
        .flush(flush),
        .ret_out(ret_out), .ret_out_vld(ret_out_vld), .ret_out_rdy(ret_out_rdy),
        .stall(stall), .ovf(ovf), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic e1, input logic [13:0] r1,
                         input logic e3, input logic [13:0] r3,
                         input logic e5, input logic [13:0] r5);
        u1_ret_en = e1; u1_ret = r1;
        u3_ret_en = e3; u3_ret = r3;
        u5_ret_en = e5; u5_ret = r5;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; ret_out_rdy = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_count", count, 0);
        chk("rst_vld", ret_out_vld, 0);
        chk("rst_out", ret_out, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ovf", ovf, 0);
        #10 rst = 1'b1;
        tick();

        // triple push then drain with rdy=1
        ret_out_rdy = 1'b1;
        drive(1, 14'h0011, 1, 14'h0022, 1, 14'h0033);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("t1_out0", ret_out, 16'h0011);
        chk("t1_cnt0", count, 3);
        tick();
        chk("t1_out1", ret_out, 16'h4022);
        chk("t1_cnt1", count, 2);
        tick();
        chk("t1_out2", ret_out, 16'h8033);
        chk("t1_cnt2", count, 1);
        tick();
        chk("t1_cnt3", count, 0);
        chk("t1_vld3", ret_out_vld, 0);
        chk("t1_out3", ret_out, 0);

        // fill to full, last u5 dropped
        ret_out_rdy = 1'b0;
        drive(1, 14'h100, 1, 14'h101, 1, 14'h102);
        tick();
        chk("t2_cnt3", count, 3);
        chk("t2_stall3", stall, 0);
        drive(1, 14'h103, 1, 14'h104, 1, 14'h105);
        tick();
        chk("t2_cnt6", count, 6);
        chk("t2_stall6", stall, 1);
        chk("t2_ovf6", ovf, 0);
        drive(1, 14'h106, 1, 14'h107, 1, 14'h108);
        tick();
        chk("t2_cnt8", count, 8);
        chk("t2_ovf8", ovf, 1);
        chk("t2_head", ret_out, 16'h0100);

        // full queue: push rides on the pop slot
        ret_out_rdy = 1'b1;
        drive(1, 14'h200, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("t3_cnt", count, 8);
        chk("t3_ovf", ovf, 1);
        chk("t3_head", ret_out, 16'h4101);
        tick(); tick(); tick();
        chk("t3_cnt5", count, 5);
        chk("t3_head5", ret_out, 16'h4104);
        chk("t3_stall5", stall, 0);

        // flush beats push and pop; ovf holds
        flush = 1'b1;
        drive(1, 14'h300, 1, 14'h301, 1, 14'h302);
        tick();
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk("t4_cnt", count, 0);
        chk("t4_vld", ret_out_vld, 0);
        chk("t4_out", ret_out, 0);
        chk("t4_ovf", ovf, 1);

        // async reset mid-cycle with 4 entries queued
        ret_out_rdy = 1'b0;
        drive(1, 14'h010, 1, 14'h020, 1, 14'h030);
        tick();
        drive(1, 14'h040, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("t5_cnt4", count, 4);
        #3 rst = 1'b0;
        #1;
        chk("t5_rcnt", count, 0);
        chk("t5_rvld", ret_out_vld, 0);
        chk("t5_rout", ret_out, 0);
        chk("t5_rovf", ovf, 0);
        chk("t5_rstall", stall, 0);
        #1 rst = 1'b1;
        drive(0, 0, 1, 14'h1234, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("t5_out", ret_out, 16'h5234);
        chk("t5_cnt", count, 1);

        // random traffic honouring stall against a scoreboard
        q.push_back(16'h5234);
        for (int cyc = 0; cyc < 1200; cyc++) begin
            logic       p;
            logic [2:0] en;
            logic [13:0] r [3];
            ret_out_rdy = 1'($urandom_range(0, 1));
            en = (q.size() > 5) ? 3'b000 : 3'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++) r[k] = 14'($urandom_range(0, 16383));
            drive(en[0], r[0], en[1], r[1], en[2], r[2]);
            p = (q.size() != 0) && ret_out_rdy;
            @(posedge clk);
            if (p) void'(q.pop_front());
            for (int k = 0; k < 3; k++)
                if (en[k]) q.push_back({2'(k), r[k]});
            #1;
            chk("rnd_cnt", count, q.size());
            chk("rnd_out", ret_out, (q.size() != 0) ? q[0] : 16'h0);
            chk("rnd_stall", stall, q.size() > 5);
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("rnd_ovf", ovf, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/fp_ret_collect.md
FP_RET_COLLECT -- requirements
Module: fp_ret_collect

Interface
REQ-001 Parameter DEPTH, default 8, queue entry count; power of two, at least 4.
REQ-002 Parameter STALL_THR, default 5; stall asserts when occupancy is above this value.
REQ-003 clk  input  1  sole clock; all state on the rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 u1_ret  input  14  retire code from FP store-lane unit 0.
REQ-006 u1_ret_en  input  1  u1_ret valid this cycle.
REQ-007 u3_ret  input  14  retire code from FP store-lane unit 1.
REQ-008 u3_ret_en  input  1  u3_ret valid this cycle.
REQ-009 u5_ret  input  14  retire code from FP store-lane unit 2.
REQ-010 u5_ret_en  input  1  u5_ret valid this cycle.
REQ-011 flush  input  1  synchronous queue clear (pipeline flush).
REQ-012 ret_out  output  16  head entry: {lane[1:0], ret[13:0]}; lane codes are u1=0, u3=1, u5=2.
REQ-013 ret_out_vld  output  1  head entry valid.
REQ-014 ret_out_rdy  input  1  consumer accepts the head entry.
REQ-015 stall  output  1  upstream shall issue no new retire this cycle.
REQ-016 ovf  output  1  sticky flag: a retire was dropped because the queue was full.
REQ-017 count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-018 A pop occurs when ret_out_vld and ret_out_rdy are both 1; at most one pop per cycle.
REQ-019 Up to three pushes occur per cycle, in order u1, u3, u5, into consecutive slots after the tail.
REQ-020 Available space = DEPTH - count + pop. Valid inputs beyond that space are dropped in order u5, then u3, then u1. Any drop sets ovf on the next edge.
REQ-021 Next count = count + accepted pushes - pop. Head and tail pointers wrap modulo DEPTH.
REQ-022 There is no bypass: an entry pushed in cycle N appears on ret_out no earlier than cycle N+1.
REQ-023 ret_out_vld = (count != 0). ret_out is registered-array data at the head and is 0 when the queue is empty.
REQ-024 stall = (count > STALL_THR), driven combinationally from registered count only. With the defaults, three pushes always fit while stall is low.
REQ-025 flush has priority over push and pop: pointers and count go to 0 on the next edge, and pushes and pops in that cycle are discarded.
REQ-026 ovf is not cleared by flush; only reset clears it.
REQ-027 Entries leave in strict push order; across lanes in the same cycle, u1 < u3 < u5.

Reset
REQ-028 When rst=0, asynchronously: count=0, head=0, tail=0, ovf=0, ret_out_vld=0, ret_out=0, stall=0.
REQ-029 Storage-array contents need not be reset; reads are masked by ret_out_vld.
REQ-030 Reset asserted mid-operation discards all entries. The first push after deassertion goes to slot 0.

Structure
REQ-031 Package fp_ret_pkg holds DEPTH, STALL_THR, the lane-code constants and the packed entry typedef {lane, ret}.
REQ-032 One sub-module, fp_ret_fifo: a multi-write (3), single-read circular buffer.
REQ-033 fp_ret_collect contains the lane compaction, drop logic, stall and ovf around fp_ret_fifo.

Verification
REQ-034 All three ret_en=1 with rets 0x0011/0x0022/0x0033 into an empty queue, rdy=1 -> ret_out shows 0x0011, 0x4022, 0x8033 on the next three cycles; count goes 3, 2, 1, 0.
REQ-035 rdy=0; apply triple pushes for two cycles -> count=6 and stall=1. Then apply three more pushes -> two accepted, u5 dropped, count=8, ovf=1.
REQ-036 count=8, rdy=1, u1_ret_en=1 in the same cycle -> push accepted using the pop slot; count stays 8 and ovf is unchanged.
REQ-037 count=5, flush=1 together with a triple push and rdy=1 -> next cycle count=0, ret_out_vld=0; ovf is held.
REQ-038 rst pulled low asynchronously mid-cycle with count=4 -> all outputs go to 0 immediately. After release, a u3 push with 0x1234 -> ret_out=0x5234 one cycle later.
REQ-039 Random pushes and pops over more than 1000 cycles against a scoreboard queue -> order is preserved, count matches, and no entry is lost while stall is honoured.
